// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared pipelined ALU.
// A tag pipeline matched to the ALU latency routes each result back to the requester that issued it.
module alu_req_arbiter #(
    parameter int ALU_LATENCY = 2,
    parameter int DATA_W      = 8
) (
    input  logic                clk_p_i,
    input  logic                reset_p_i,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [DATA_W-1:0]   req0_a_i,
    input  logic [DATA_W-1:0]   req0_b_i,
    input  logic [2:0]          req0_inst_i,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [DATA_W-1:0]   req1_a_i,
    input  logic [DATA_W-1:0]   req1_b_i,
    input  logic [2:0]          req1_inst_i,
    output logic [DATA_W-1:0]   alu_a_o,
    output logic [DATA_W-1:0]   alu_b_o,
    output logic [2:0]          alu_inst_o,
    input  logic [2*DATA_W-1:0] alu_data_i,
    output logic                rsp0_valid_o,
    output logic                rsp1_valid_o,
    output logic [2*DATA_W-1:0] rsp_data_o,
    output logic                busy_o
);

    localparam logic [2:0] INST_NOP = 3'b111;

    logic                  rr_reg;
    logic                  grant0;
    logic                  grant1;
    logic [ALU_LATENCY-1:0] tag_valid_reg;
    logic [ALU_LATENCY-1:0] tag_id_reg;
    logic                  rsp0_valid_reg;
    logic                  rsp1_valid_reg;
    logic [2*DATA_W-1:0]   rsp_data_reg;

    // rr_reg == 0 favours requester 0 when both are valid.
    always_comb begin
        grant0 = req0_valid_i & (~req1_valid_i | ~rr_reg);
        grant1 = req1_valid_i & (~req0_valid_i |  rr_reg);
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    always_comb begin
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_inst_o = INST_NOP;
        if (grant0) begin
            alu_a_o    = req0_a_i;
            alu_b_o    = req0_b_i;
            alu_inst_o = req0_inst_i;
        end else if (grant1) begin
            alu_a_o    = req1_a_i;
            alu_b_o    = req1_b_i;
            alu_inst_o = req1_inst_i;
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            rr_reg <= 1'b0;
        end else if (grant0) begin
            rr_reg <= 1'b1;
        end else if (grant1) begin
            rr_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= 1'b0;
        end else begin
            tag_valid_reg[0] <= grant0 | grant1;
            tag_id_reg[0]    <= grant1;
        end
    end

    generate
        for (genvar gi = 1; gi < ALU_LATENCY; gi++) begin : g_tag_stage
            always_ff @(posedge clk_p_i) begin
                if (reset_p_i) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= 1'b0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    // The last tag stage lines up with the ALU output register, so capture alu_data_i now.
    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp_data_reg   <= '0;
        end else if (tag_valid_reg[ALU_LATENCY-1]) begin
            rsp0_valid_reg <= ~tag_id_reg[ALU_LATENCY-1];
            rsp1_valid_reg <=  tag_id_reg[ALU_LATENCY-1];
            rsp_data_reg   <= alu_data_i;
        end else begin
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
        end
    end

    assign rsp0_valid_o = rsp0_valid_reg;
    assign rsp1_valid_o = rsp1_valid_reg;
    assign rsp_data_o   = rsp_data_reg;
    assign busy_o       = (|tag_valid_reg) | rsp0_valid_reg | rsp1_valid_reg;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a 2-stage ALU model feeds the DUT, and a scoreboard queue
// holds expected {requester, data, due cycle} for every accepted op.
module tb_alu_req_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_p_i;
    logic          req0_valid_i, req1_valid_i;
    logic          req0_ready_o, req1_ready_o;
    logic [DW-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic [2:0]    req0_inst_i, req1_inst_i;
    logic [DW-1:0] alu_a_o, alu_b_o;
    logic [2:0]    alu_inst_o;
    logic [2*DW-1:0] alu_data_i;
    logic          rsp0_valid_o, rsp1_valid_o;
    logic [2*DW-1:0] rsp_data_o;
    logic          busy_o;

    typedef struct {
        logic          id;
        logic [2*DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.ALU_LATENCY(2), .DATA_W(DW)) dut (
        .clk_p_i      (clk),
        .reset_p_i    (reset_p_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req0_inst_i  (req0_inst_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .req1_inst_i  (req1_inst_i),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_inst_o   (alu_inst_o),
        .alu_data_i   (alu_data_i),
        .rsp0_valid_o (rsp0_valid_o),
        .rsp1_valid_o (rsp1_valid_o),
        .rsp_data_o   (rsp_data_o),
        .busy_o       (busy_o)
    );

    // Stand-in for the HW2 ALU: 000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor, 110 xnor, 111 nop.
    function automatic logic [2*DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [2:0] inst);
        logic [2*DW-1:0] ax, bx;
        ax = {{DW{1'b0}}, a};
        bx = {{DW{1'b0}}, b};
        case (inst)
            3'b000:  return ax + bx;
            3'b001:  return ax - bx;
            3'b010:  return ax * bx;
            3'b011:  return ax & bx;
            3'b100:  return ax | bx;
            3'b101:  return ax ^ bx;
            3'b110:  return {{DW{1'b0}}, ~(a ^ b)};
            default: return '0;
        endcase
    endfunction

    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [2:0]    alu_inst_q;
    initial begin
        alu_a_q = '0; alu_b_q = '0; alu_inst_q = 3'b111; alu_data_i = '0;
    end
    always @(posedge clk) begin
        alu_a_q    <= alu_a_o;
        alu_b_q    <= alu_b_o;
        alu_inst_q <= alu_inst_o;
        alu_data_i <= alu_ref(alu_a_q, alu_b_q, alu_inst_q);
    end

    // One clock: score responses and record handshakes at the falling edge, then advance.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rsp0_valid_o || rsp1_valid_o) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected cyc=%0d: rsp0=%0b rsp1=%0b data=%h, required no response",
                         cyc, rsp0_valid_o, rsp1_valid_o, rsp_data_o);
            end else begin
                e = sb_q.pop_front();
                if ({rsp1_valid_o, rsp0_valid_o} !== (e.id ? 2'b10 : 2'b01) ||
                    rsp_data_o !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL sb_rsp cyc=%0d: rsp0=%0b rsp1=%0b data=%h, required id=%0d data=%h at cyc=%0d",
                             cyc, rsp0_valid_o, rsp1_valid_o, rsp_data_o, e.id, e.data, e.due);
                end
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            total++;
            bad++;
            e = sb_q.pop_front();
            $display("FAIL sb_missing cyc=%0d: no response, required id=%0d data=%h", cyc, e.id, e.data);
        end
        if (reset_p_i) begin
            sb_q.delete();
        end else begin
            if (req0_valid_i && req0_ready_o)
                sb_q.push_back('{1'b0, alu_ref(req0_a_i, req0_b_i, req0_inst_i), cyc + 3});
            if (req1_valid_i && req1_ready_o)
                sb_q.push_back('{1'b1, alu_ref(req1_a_i, req1_b_i, req1_inst_i), cyc + 3});
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        reset_p_i = 1'b1;
        step();
        step();
        reset_p_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({rsp0_valid_o, rsp1_valid_o, busy_o, req0_ready_o, req1_ready_o} !== 5'b0 ||
            rsp_data_o !== 16'h0000 || alu_inst_o !== 3'b111) begin
            bad++;
            $display("FAIL reset_state: rsp0=%0b rsp1=%0b busy=%0b rdy=%0b%0b data=%h inst=%b, required all 0, inst=111",
                     rsp0_valid_o, rsp1_valid_o, busy_o, req0_ready_o, req1_ready_o, rsp_data_o, alu_inst_o);
        end
        step();
    endtask

    task automatic test_single_op();
        req0_a_i = 8'h05; req0_b_i = 8'h03; req0_inst_i = 3'b000; req0_valid_i = 1'b1;
        #1;
        total++;
        if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0 || alu_a_o !== 8'h05 ||
            alu_b_o !== 8'h03 || alu_inst_o !== 3'b000) begin
            bad++;
            $display("FAIL single_grant: rdy0=%0b rdy1=%0b alu=%h/%h/%b, required 1 0 05/03/000",
                     req0_ready_o, req1_ready_o, alu_a_o, alu_b_o, alu_inst_o);
        end
        step();
        req0_valid_i = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL single_busy: busy=%0b, required 1", busy_o);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req0_a_i = 8'h10; req0_b_i = 8'h10; req0_inst_i = 3'b010; req0_valid_i = 1'b1;
        req1_a_i = 8'h03; req1_b_i = 8'h05; req1_inst_i = 3'b001; req1_valid_i = 1'b1;
        #1;
        total++;
        if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL simul_first: rdy0=%0b rdy1=%0b, required 1 0", req0_ready_o, req1_ready_o);
        end
        step();
        req0_valid_i = 1'b0;
        #1;
        total++;
        if (req1_ready_o !== 1'b1 || alu_a_o !== 8'h03 || alu_inst_o !== 3'b001) begin
            bad++;
            $display("FAIL simul_second: rdy1=%0b alu_a=%h inst=%b, required 1 03 001",
                     req1_ready_o, alu_a_o, alu_inst_o);
        end
        step();
        req1_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_fairness();
        do_reset();
        req0_a_i = DW'($urandom); req0_b_i = DW'($urandom); req0_inst_i = 3'($urandom_range(0, 7));
        req1_a_i = DW'($urandom); req1_b_i = DW'($urandom); req1_inst_i = 3'($urandom_range(0, 7));
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic g0, g1;
            #1;
            g0 = req0_ready_o;
            g1 = req1_ready_o;
            total++;
            if (g0 !== ((i % 2) == 0) || g1 !== ((i % 2) == 1)) begin
                bad++;
                $display("FAIL fair_grant[%0d]: rdy0=%0b rdy1=%0b, required grant to %0d", i, g0, g1, i % 2);
            end
            step();
            if (g0) begin
                req0_a_i = DW'($urandom); req0_b_i = DW'($urandom); req0_inst_i = 3'($urandom_range(0, 7));
            end
            if (g1) begin
                req1_a_i = DW'($urandom); req1_b_i = DW'($urandom); req1_inst_i = 3'($urandom_range(0, 7));
            end
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (alu_inst_o !== 3'b111 || alu_a_o !== 8'h00 || alu_b_o !== 8'h00 ||
                req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_drive[%0d]: alu=%h/%h/%b rdy=%0b%0b, required 00/00/111 rdy 00",
                         i, alu_a_o, alu_b_o, alu_inst_o, req0_ready_o, req1_ready_o);
            end
            if (i >= 3) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_busy[%0d]: busy=%0b, required 0", i, busy_o);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        req1_a_i = 8'hFF; req1_b_i = 8'h0F; req1_inst_i = 3'b011; req1_valid_i = 1'b1;
        #1;
        total++;
        if (req1_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL midflight_accept: rdy1=%0b, required 1", req1_ready_o);
        end
        step();
        req1_valid_i = 1'b0;
        reset_p_i = 1'b1;
        step();
        reset_p_i = 1'b0;
        req0_a_i = 8'h21; req0_b_i = 8'h02; req0_inst_i = 3'b010; req0_valid_i = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || req0_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL midflight_after_reset: busy=%0b rdy0=%0b, required busy 0 rdy0 1", busy_o, req0_ready_o);
        end
        step();
        req0_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            req1_a_i = DW'(i); req1_b_i = 8'h01; req1_inst_i = 3'b000; req1_valid_i = 1'b1;
            #1;
            total++;
            if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL stream_ready[%0d]: rdy0=%0b rdy1=%0b, required 0 1", i, req0_ready_o, req1_ready_o);
            end
            step();
        end
        req1_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
    endtask

    initial begin
        reset_p_i = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_a_i = '0; req0_b_i = '0; req0_inst_i = '0;
        req1_a_i = '0; req1_b_i = '0; req1_inst_i = '0;
        test_reset();
        test_single_op();
        test_simultaneous();
        test_fairness();
        test_idle();
        test_reset_midflight();
        test_back_to_back();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 8-bit, 2-stage pipelined HW2 ALU.
- Accepts operations through valid/ready handshakes and drives the ALU operand and instruction inputs.
- Tracks in-flight operations with a tag pipeline matched to the ALU latency.
- Returns each 16-bit result to the requester that issued it, one op issued per cycle maximum.

Parameters:
- ALU_LATENCY, 2, cycles from ALU input sample edge to result on alu_data_i (input reg + output reg).
- DATA_W, 8, operand width; result width is 2*DATA_W.

Ports:
- clk_p_i  in  1  clock, rising edge.
- reset_p_i  in  1  synchronous reset, active-high.
- req0_valid_i  in  1  requester 0 has an op.
- req0_ready_o  out  1  requester 0 op accepted this cycle.
- req0_a_i  in  DATA_W  operand A.
- req0_b_i  in  DATA_W  operand B.
- req0_inst_i  in  3  ALU opcode.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_inst_i: same as requester 0, for requester 1.
- alu_a_o  out  DATA_W  ALU operand A.
- alu_b_o  out  DATA_W  ALU operand B.
- alu_inst_o  out  3  ALU opcode.
- alu_data_i  in  2*DATA_W  ALU result.
- rsp0_valid_o  out  1  one-cycle pulse: rsp_data_o belongs to requester 0.
- rsp1_valid_o  out  1  one-cycle pulse: rsp_data_o belongs to requester 1.
- rsp_data_o  out  2*DATA_W  registered result.
- busy_o  out  1  any op in flight or response pending.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on reset_p_i; all state clears on the rising edge with reset_p_i=1.
- Reset values: rsp0_valid_o=0, rsp1_valid_o=0, rsp_data_o=0, busy_o=0, rr pointer=0 (requester 0 favoured), all tag pipeline valid bits=0.
- Handshake: a transfer occurs in a cycle where reqN_valid_i=1 and reqN_ready_o=1.
  - reqN_ready_o is combinational from both valids and the rr pointer.
  - Requester holds a, b, inst stable while valid=1 and ready=0.
  - Never both ready in one cycle. ready=0 when valid=0.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester indicated by the rr pointer.
  - After any grant, the pointer moves to the non-granted requester.
  - No grant: pointer holds.
- ALU drive (combinational):
  - On a grant cycle, alu_a_o/alu_b_o/alu_inst_o = granted requester's fields.
  - Otherwise alu_a_o=0, alu_b_o=0, alu_inst_o=3'b111 (NOP, result 0).
- Tag pipeline: ALU_LATENCY-deep shift register of {valid, id}. Stage 0 loads {grant, granted id} each cycle.
- Response:
  - When the last stage is valid, on the next edge: rsp_data_o<=alu_data_i, rspN_valid_o<=1 for the tagged id.
  - Otherwise both valids <=0 and rsp_data_o holds.
  - Handshake-to-response latency = ALU_LATENCY+1 = 3 cycles (accept in cycle T, rspN_valid_o high in cycle T+3, exactly one cycle).
- No response backpressure: the requester must consume on the pulse. Back-to-back issue yields back-to-back responses in issue order.
- Throughput: one op per cycle sustained. Under continuous dual requests, grants strictly alternate 0,1,0,1…
- busy_o = OR of tag-stage valids OR rsp0_valid_o OR rsp1_valid_o.
- Result width: as produced by the ALU. The arbiter does not modify or inspect data. Opcode 3'b111 from a requester is legal and returns 0.
- Reset mid-operation: all in-flight tags are discarded and no response is emitted for ops accepted before reset. Stale alu_data_i is ignored. Ops may be accepted in the first cycle after reset deasserts.
- Reset asserted in a cycle with valid=1: ready is still computed combinationally, but the tag load is overridden by reset, so the op is lost. Requesters must not issue during reset.

Test Plan:
- Single op: req0 a=8'h05, b=8'h03, inst=000 accepted at T -> rsp0_valid_o=1 only in T+3, rsp_data_o=16'h0008; rsp1_valid_o stays 0.
- Simultaneous requests after reset: req0 {0x10,0x10,010}, req1 {0x03,0x05,001} both valid at T.
  - req0 granted at T, req1 at T+1.
  - rsp0 16'h0100 at T+3; rsp1 16'hFFFE at T+4.
- Fairness: both requesters hold valid for 8 cycles -> grant sequence 0,1,0,1,0,1,0,1. Responses alternate rsp0/rsp1 on consecutive cycles with matching data.
- Idle: no valids for 5 cycles -> alu_inst_o=3'b111, alu_a_o=alu_b_o=0, busy_o=0 from the 4th idle cycle, no rsp pulses.
- Reset mid-flight: accept req1 {0xFF,0x0F,011} at T, reset_p_i=1 in T+1 -> no rsp1 pulse at T+3; busy_o=0 after reset edge. An op accepted right after reset returns normally 3 cycles later.
- Single-requester streaming: req1 valid continuously with a=0..3, b=1, inst=000 -> ready high every cycle, rsp1 data 1,2,3,4 on consecutive cycles.
